// File: rtl/mod_reduce_arbiter.sv
// Round-robin share of one Barrett engine among NUM_REQ requesters; MODRED_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: accept -> eng_start next cycle -> rsp_valid the cycle after eng_done.
// Backpressure: response held in RESP until rsp_ready; req_ready stays 0 outside IDLE.
module mod_reduce_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int DATA_WIDTH     = 48,
    parameter int Q_WIDTH        = 23,
    parameter int Q_DEFAULT      = 8380417,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [Q_WIDTH-1:0]            rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_err,
    input  logic                          cfg_we,
    input  logic [Q_WIDTH-1:0]            cfg_q,
    output logic                          busy,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_data_in,
    output logic [Q_WIDTH-1:0]            eng_q,
    input  logic                          eng_done,
    input  logic [Q_WIDTH-1:0]            eng_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [Q_WIDTH-1:0]      r_q;
    logic [DATA_WIDTH-1:0]   r_op;
    logic [ID_W-1:0]         r_id;
    logic [Q_WIDTH-1:0]      r_res;
    logic                    w_gnt_vld;
    logic [ID_W-1:0]         w_gnt_id;
    logic [DATA_WIDTH-1:0]   w_gnt_dat;
    logic                    w_accept;
    logic                    w_timeout;

`ifdef MODRED_ARB_TIMEOUT_EN
    logic                    r_err;
    logic [3:0]              r_tcnt;
    assign w_timeout = (r_state == S_WAIT) && !eng_done && (r_tcnt == 4'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Search upward from rr_ptr with wrap; descending loop so the nearest valid wins.
    always_comb begin
        logic [ID_W:0] w_sum;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            if (req_valid[w_sum[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == w_gnt_id) w_gnt_dat = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_accept    = (r_state == S_IDLE) && !cfg_we && w_gnt_vld;
    assign req_ready   = w_accept ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_res;
    assign rsp_id      = r_id;
    assign busy        = (r_state != S_IDLE);
    assign eng_start   = (r_state == S_ISSUE);
    assign eng_data_in = r_op;
    assign eng_q       = r_q;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (eng_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_q      <= Q_WIDTH'(Q_DEFAULT);
            r_op     <= '0;
            r_id     <= '0;
            r_res    <= '0;
        end else begin
            // Modulus only moves in IDLE so an in-flight operation sees one Q.
            if (r_state == S_IDLE && cfg_we && cfg_q != '0) r_q <= cfg_q;
            if (w_accept) begin
                r_op <= w_gnt_dat;
                r_id <= w_gnt_id;
            end
            if (r_state == S_WAIT && eng_done) r_res <= eng_data_out;
            else if (w_timeout) r_res <= '0;
            if (r_state == S_RESP && rsp_ready) r_rr_ptr <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
        end
    end

`ifdef MODRED_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= 1'b0;
            r_tcnt <= '0;
        end else begin
            if (r_state == S_ISSUE) r_tcnt <= '0;
            else if (r_state == S_WAIT) r_tcnt <= r_tcnt + 1'b1;
            if (w_accept) r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end
`endif

endmodule
